// File: rtl/egress_queue_pkg.sv
// ---------------------------------------------------------------------------
// egress_queue_pkg
// Shared definitions for the egress queue: statistics counter width and a
// saturating increment helper used by the optional statistics counters.
// Optional feature macro used by the consumers: EGRESS_QUEUE_STATS_EN.
// ---------------------------------------------------------------------------
package egress_queue_pkg;

    localparam int STAT_W = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        logic [STAT_W-1:0] r;
        if (v == {STAT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STAT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/egress_ram.sv
// ---------------------------------------------------------------------------
// egress_ram
// Simple dual-port storage array, DEPTH x WIDTH, one write port and one
// read port. The read is registered: rdata shows mem[raddr] one cycle after
// re, and it holds its value on cycles without re. Contents are not reset.
//
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module egress_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds the last word until the next read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/egress_queue.sv
// ---------------------------------------------------------------------------
// egress_queue
// Per-port egress FIFO with a registered show-ahead output. Words live in
// three places: the output register (dout/dout_valid), the read register of
// the storage array (a prefetched next word) and the array itself. level
// counts all of them. A write into an otherwise empty queue whose output
// register is free (or being drained) goes straight into the output register.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   wr_in       in   write strobe
//   data_in     in   write data [WIDTH]
//   full_out    out  registered flow control, 1 when next level >= DEPTH-SLACK
//   dout        out  egress data [WIDTH]
//   dout_valid  out  dout holds a valid word
//   dout_ready  in   consumer accepts dout
//   level       out  stored word count [$clog2(DEPTH+1)]
//   overflow    out  sticky, set by a dropped write
//   acc_cnt     out  accepted-write count (only with EGRESS_QUEUE_STATS_EN)
//   drop_cnt    out  dropped-write count  (only with EGRESS_QUEUE_STATS_EN)
//
// Optional feature macro: EGRESS_QUEUE_STATS_EN adds the saturating
// acc_cnt/drop_cnt counters and ports.
// ---------------------------------------------------------------------------
module egress_queue
    import egress_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int SLACK = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       full_out,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
`ifdef EGRESS_QUEUE_STATS_EN
    ,
    output logic [STAT_W-1:0]          acc_cnt,
    output logic [STAT_W-1:0]          drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    arr_cnt_r;
    logic [LW-1:0]    level_r;
    logic             mvalid_r;
    logic             full_r;
    logic             ovf_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;

    logic             xfer_s;
    logic             out_free_s;
    logic             accept_s;
    logic             drop_s;
    logic             move_s;
    logic             bypass_s;
    logic             ram_we_s;
    logic             ram_re_s;
    logic [LW-1:0]    level_nx_s;
    logic [LW-1:0]    arr_cnt_nx_s;
    logic [WIDTH-1:0] ram_rdata_s;

    // Handshake, acceptance and routing decisions for the current cycle.
    always_comb begin
        xfer_s     = dout_valid_r & dout_ready;
        out_free_s = ~dout_valid_r | xfer_s;
        accept_s   = wr_in & ((level_r < LW'(DEPTH)) | xfer_s);
        drop_s     = wr_in & ~accept_s;
        // The prefetched word moves into the output register when it frees up.
        move_s     = mvalid_r & out_free_s;
        // Nothing older is buffered anywhere: the new word can skip the array.
        bypass_s   = accept_s & out_free_s & ~mvalid_r & (arr_cnt_r == {LW{1'b0}});
        ram_we_s   = accept_s & ~bypass_s;
        // Prefetch whenever the read register is empty or being consumed.
        ram_re_s   = (arr_cnt_r != {LW{1'b0}}) & (~mvalid_r | move_s);
        level_nx_s = level_r + {{(LW-1){1'b0}}, accept_s} - {{(LW-1){1'b0}}, xfer_s};
        arr_cnt_nx_s = arr_cnt_r + {{(LW-1){1'b0}}, ram_we_s} - {{(LW-1){1'b0}}, ram_re_s};
    end

    // Occupancy, flow control and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r   <= {LW{1'b0}};
            arr_cnt_r <= {LW{1'b0}};
            full_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            level_r   <= level_nx_s;
            arr_cnt_r <= arr_cnt_nx_s;
            full_r    <= (level_nx_s >= LW'(DEPTH - SLACK));
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Array pointers; they wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, ram_we_s};
            rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, ram_re_s};
        end
    end

    // Tracks whether the array read register holds a word not yet moved out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mvalid_r <= 1'b0;
        end else if (ram_re_s) begin
            mvalid_r <= 1'b1;
        end else if (move_s) begin
            mvalid_r <= 1'b0;
        end
    end

    // Show-ahead output register; holds steady while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r       <= {WIDTH{1'b0}};
            dout_valid_r <= 1'b0;
        end else if (move_s) begin
            dout_r       <= ram_rdata_s;
            dout_valid_r <= 1'b1;
        end else if (bypass_s) begin
            dout_r       <= data_in;
            dout_valid_r <= 1'b1;
        end else if (xfer_s) begin
            dout_valid_r <= 1'b0;
        end
    end

    egress_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .waddr (wr_ptr_r),
        .wdata (data_in),
        .re    (ram_re_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

`ifdef EGRESS_QUEUE_STATS_EN
    logic [STAT_W-1:0] acc_cnt_r;
    logic [STAT_W-1:0] drop_cnt_r;

    // Saturating accepted/dropped write counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_r  <= {STAT_W{1'b0}};
            drop_cnt_r <= {STAT_W{1'b0}};
        end else begin
            if (accept_s) begin
                acc_cnt_r <= sat_inc(acc_cnt_r);
            end
            if (drop_s) begin
                drop_cnt_r <= sat_inc(drop_cnt_r);
            end
        end
    end

    assign acc_cnt  = acc_cnt_r;
    assign drop_cnt = drop_cnt_r;
`endif

    assign full_out   = full_r;
    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign level      = level_r;
    assign overflow   = ovf_r;

endmodule

// File: tb/tb_egress_queue.sv
// ---------------------------------------------------------------------------
// tb_egress_queue
// Self-checking bench for egress_queue (WIDTH=32, DEPTH=16, SLACK=2).
// A table of hand-computed vectors covers reset, show-ahead latency,
// streaming, stall and bypass; hand-written sequences cover fill to
// full, overflow, write-at-full with drain, random traffic across the
// pointer wrap and reset mid-traffic, checked against a queue model.
// ---------------------------------------------------------------------------
module tb_egress_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int SLACK = 2;
    localparam int LW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_in;
    logic [WIDTH-1:0] data_in;
    logic             full_out;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [LW-1:0]    level;
    logic             overflow;
`ifdef EGRESS_QUEUE_STATS_EN
    logic [31:0]      acc_cnt;
    logic [31:0]      drop_cnt;
`endif

    egress_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_in      (wr_in),
        .data_in    (data_in),
        .full_out   (full_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .level      (level),
        .overflow   (overflow)
`ifdef EGRESS_QUEUE_STATS_EN
        ,
        .acc_cnt    (acc_cnt),
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] sb[$];
    int          mlvl  = 0;
    logic        movf  = 1'b0;
    int          macc  = 0;
    int          mdrop = 0;
    int          n_out = 0;
    logic [31:0] last_out = 32'h0;

    typedef struct {
        logic        rst;
        logic        wr;
        logic [31:0] data;
        logic        rdy;
        logic        exp_dv;
        logic        chk_dout;
        logic [31:0] exp_dout;
        int          exp_lvl;
        logic        exp_full;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle with the queue model: inputs applied, edge, outputs compared.
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        logic x;
        logic acc;
        logic [31:0] exp;
        wr_in      = w;
        data_in    = d;
        dout_ready = r;
        x   = dout_valid & r;
        acc = w & ((mlvl < DEPTH) | x);
        if (x) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL xfer_when_empty: got transfer expected none at %0t", $time);
            end else begin
                exp = sb.pop_front();
                chk("dout_order", dout, exp);
                last_out = dout;
                n_out++;
            end
            mlvl--;
        end
        if (acc) begin
            sb.push_back(d);
            mlvl++;
            macc++;
        end else if (w) begin
            movf = 1'b1;
            mdrop++;
        end
        @(posedge clk);
        #1;
        chk("level", 32'(level), 32'(mlvl));
        chk("overflow", 32'(overflow), 32'(movf));
        chk("full_out", 32'(full_out), 32'(mlvl >= DEPTH - SLACK));
        if (mlvl == 0) begin
            chk("valid_when_empty", 32'(dout_valid), 32'd0);
        end
`ifdef EGRESS_QUEUE_STATS_EN
        chk("acc_cnt", acc_cnt, 32'(macc));
        chk("drop_cnt", drop_cnt, 32'(mdrop));
`endif
    endtask

    // One reset cycle with a write and ready presented; all must be ignored.
    task automatic do_reset();
        rst_n      = 1'b0;
        wr_in      = 1'b1;
        data_in    = 32'hDEAD_BEEF;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        wr_in      = 1'b0;
        dout_ready = 1'b0;
        sb.delete();
        mlvl  = 0;
        movf  = 1'b0;
        macc  = 0;
        mdrop = 0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_full", 32'(full_out), 32'd0);
        chk("rst_dout", dout, 32'd0);
`ifdef EGRESS_QUEUE_STATS_EN
        chk("rst_acc_cnt", acc_cnt, 32'd0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rw;
        logic        rr;
        logic [31:0] rd;
        int          guard;

        rst_n      = 1'b0;
        wr_in      = 1'b0;
        data_in    = 32'h0;
        dout_ready = 1'b0;

        //           rst   wr    data       rdy   dv    chkd  dout      lvl full  ovf
        vecs[0]  = '{1'b0, 1'b1, 32'h99, 1'b1, 1'b0, 1'b1, 32'h00, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11, 1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'h12, 1'b1, 1'b1, 1'b1, 32'h12, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h13, 1'b1, 1'b1, 1'b1, 32'h13, 1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 32'h14, 1'b1, 1'b1, 1'b1, 32'h14, 1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h15, 1'b1, 1'b1, 1'b1, 32'h15, 1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'h21, 1'b0, 1'b1, 1'b1, 32'h21, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 32'h21, 2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h21, 2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h22, 1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h31, 1'b0, 1'b1, 1'b1, 32'h31, 1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'h32, 1'b1, 1'b1, 1'b1, 32'h32, 1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 0, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            rst_n      = vecs[i].rst;
            wr_in      = vecs[i].wr;
            data_in    = vecs[i].data;
            dout_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(dout_valid), 32'(vecs[i].exp_dv));
            if (vecs[i].chk_dout) begin
                chk($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            end
            chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_lvl));
            chk($sformatf("vec%0d_full", i), 32'(full_out), 32'(vecs[i].exp_full));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // Fill with the consumer stalled: full_out rises with the 14th write.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, 32'h40 + 32'(i), 1'b0);
            if (i == 12) begin
                chk("fill13_full", 32'(full_out), 32'd0);
            end
        end
        chk("fill14_full", 32'(full_out), 32'd1);
        chk("fill14_level", 32'(level), 32'd14);
        cycle(1'b1, 32'h4E, 1'b0);
        cycle(1'b1, 32'h4F, 1'b0);
        chk("fill16_level", 32'(level), 32'd16);
        chk("fill16_ovf", 32'(overflow), 32'd0);
        chk("fill16_head", dout, 32'h40);

        // Write at full without a transfer is dropped.
        cycle(1'b1, 32'hAA, 1'b0);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_level", 32'(level), 32'd16);
        chk("drop_head", dout, 32'h40);
`ifdef EGRESS_QUEUE_STATS_EN
        chk("drop_cnt_one", drop_cnt, 32'd1);
`endif

        // Write at full with a simultaneous transfer is accepted.
        cycle(1'b1, 32'hBB, 1'b1);
        chk("full_xfer_level", 32'(level), 32'd16);
        n_out = 0;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            cycle(1'b0, 32'h0, 1'b1);
            guard++;
        end
        chk("drain_done", 32'(sb.size()), 32'd0);
        chk("bb_position", 32'(n_out), 32'd16);
        chk("bb_last", last_out, 32'hBB);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Random traffic across the pointer wrap, then reset mid-traffic.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rw = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 1) != 0);
            rd = $urandom;
            cycle(rw, rd, rr);
        end
        do_reset();
        cycle(1'b1, 32'h5A, 1'b0);
        chk("post_rst_valid", 32'(dout_valid), 32'd1);
        chk("post_rst_dout", dout, 32'h5A);
        cycle(1'b1, 32'h5B, 1'b1);
        chk("post_rst_next", dout, 32'h5B);
        cycle(1'b0, 32'h0, 1'b1);
        chk("post_rst_empty", 32'(dout_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
